// File: rtl/queue_ctl_pkg.sv
// Shared definitions for the queue_ctl FIFO: default sizes, the push/pop operation encoding
// and the helpers that derive the capacity and level width from DEPTH_BITS.
package queue_ctl_pkg;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_DEPTH_BITS   = 4;
  localparam int DEF_AFULL_LEVEL  = 12;
  localparam int DEF_AEMPTY_LEVEL = 4;

  // Accepted operations for one edge, encoded as {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } queue_op_e;

  function automatic int capacity(input int depth_bits);
    return 1 << depth_bits;
  endfunction

  function automatic int level_bits(input int depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/queue_ctl_ram.sv
// Storage array for queue_ctl: one synchronous write port and one asynchronous read port,
// so the head word reaches dat_o with zero read latency.
module queue_ram #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/queue_ctl.sv
// Parametrised synchronous FIFO controller with level, watermarks, flush and defined push+pop at
// empty/full. Sticky overflow/underflow flags exist only when QUEUE_ERR_FLAGS_EN is defined.
module queue_ctl
  import queue_ctl_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int DEPTH_BITS   = DEF_DEPTH_BITS,
  parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
  parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic [DATA_BITS-1:0]  dat_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  oe_i,
  output logic [DATA_BITS-1:0]  dat_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_BITS:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int LEVEL_BITS = level_bits(DEPTH_BITS);
  localparam logic [LEVEL_BITS-1:0] CAP_LEVEL    = LEVEL_BITS'(capacity(DEPTH_BITS));
  localparam logic [LEVEL_BITS-1:0] AFULL_MARK   = LEVEL_BITS'(AFULL_LEVEL);
  localparam logic [LEVEL_BITS-1:0] AEMPTY_MARK  = LEVEL_BITS'(AEMPTY_LEVEL);

  logic [DEPTH_BITS-1:0] rp;
  logic [DEPTH_BITS-1:0] wp;
  logic [LEVEL_BITS-1:0] level;
  logic                  is_full;
  logic                  is_empty;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ram_we;
  logic [DATA_BITS-1:0]  head;
  queue_op_e             op;

  assign is_full  = (level == CAP_LEVEL);
  assign is_empty = (level == '0);

  // A push at full is only allowed when the simultaneous pop frees a slot on the same edge.
  assign push_ok = push_i & (~is_full | pop_i);
  assign pop_ok  = pop_i & ~is_empty;
  assign op      = queue_op_e'({push_ok, pop_ok});
  assign ram_we  = push_ok & ~flush_i & ~reset_i;

  queue_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .waddr (wp),
    .wdata (dat_i),
    .raddr (rp),
    .rdata (head)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
    end else begin
      case (op)
        OP_POP: begin
          rp    <= rp + 1'b1;
          level <= level - 1'b1;
        end
        OP_PUSH: begin
          wp    <= wp + 1'b1;
          level <= level + 1'b1;
        end
        OP_BOTH: begin
          rp <= rp + 1'b1;
          wp <= wp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dat_o          = oe_i ? head : '0;
  assign full_o         = is_full;
  assign empty_o        = is_empty;
  assign almost_full_o  = (level >= AFULL_MARK);
  assign almost_empty_o = (level <= AEMPTY_MARK);
  assign level_o        = level;

`ifdef QUEUE_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // A new rejection on the same edge as clr_err_i keeps the flag set; flush leaves flags alone.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (push_i & ~push_ok & ~flush_i) | (overflow_q & ~clr_err_i);
      underflow_q <= (pop_i & ~pop_ok & ~flush_i) | (underflow_q & ~clr_err_i);
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_queue_ctl.sv
// Scoreboard bench for queue_ctl: the driver queues the expected post-edge state for every
// stimulus cycle and a separate monitor compares it against the DUT on the falling edge.
module tb_queue_ctl;

`ifdef QUEUE_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       flush_i = 1'b0;
  logic [7:0] dat_i = '0;
  logic       push_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       oe_i = 1'b1;
  logic       clr_err_i = 1'b0;
  logic [7:0] dat_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o;
  logic [4:0] level_o;
  logic       overflow_o, underflow_o;

  queue_ctl dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .dat_i          (dat_i),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .oe_i           (oe_i),
    .dat_o          (dat_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .clr_err_i      (clr_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         level;
    bit         dat_chk;
    logic [7:0] dat;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the state the DUT must show after the next rising edge.
  task automatic applyStimulus(input bit rst, input bit fl, input bit psh, input bit pp,
                               input logic [7:0] d, input bit oe, input bit clr);
    exp_t e;
    bit   push_ok, pop_ok;
    @(negedge clk);
    #1;
    reset_i = rst; flush_i = fl; push_i = psh; pop_i = pp;
    dat_i = d; oe_i = oe; clr_err_i = clr;
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      model_q.delete();
      if (clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      pop_ok  = pp && (model_q.size() != 0);
      push_ok = psh && ((model_q.size() < 16) || pp);
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
      m_ovf = ERR_EN && ((psh && !push_ok) || (m_ovf && !clr));
      m_unf = ERR_EN && ((pp && !pop_ok) || (m_unf && !clr));
    end
    e.level   = model_q.size();
    e.dat_chk = !oe || (model_q.size() != 0);
    e.dat     = oe ? ((model_q.size() != 0) ? model_q[0] : 8'h00) : 8'h00;
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit oe);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, oe, 1'b0);
  endtask

  task automatic pushWord(input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic pushPop(input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, d, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: compares each queued expectation on the falling edge after its rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("level", 32'(level_o), 32'(e.level));
        checkOutput("full", 32'(full_o), 32'(e.level == 16));
        checkOutput("empty", 32'(empty_o), 32'(e.level == 0));
        checkOutput("almost_full", 32'(almost_full_o), 32'(e.level >= 12));
        checkOutput("almost_empty", 32'(almost_empty_o), 32'(e.level <= 4));
        checkOutput("overflow", 32'(overflow_o), 32'(e.ovf));
        checkOutput("underflow", 32'(underflow_o), 32'(e.unf));
        if (e.dat_chk) checkOutput("dat_o", 32'(dat_o), 32'(e.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset, single push, then output-enable gating.
    doReset();
    pushWord(8'hA5);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);

    // Fill to capacity, then one push too many.
    doReset();
    for (int i = 0; i < 16; i++) pushWord(8'(i));
    pushWord(8'h99);
    idle(1'b1);

    // Drain in order, then one pop too many; clear the flags afterwards.
    for (int i = 0; i < 16; i++) popWord();
    popWord();
    idle(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Steady push+pop at level 5 long enough for both pointers to wrap.
    doReset();
    for (int i = 0; i < 5; i++) pushWord(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) pushPop(8'h50 + 8'(i));
    idle(1'b1);

    // Push+pop at empty, then at full.
    doReset();
    pushPop(8'h3C);
    idle(1'b1);
    for (int i = 0; i < 15; i++) pushWord(8'hC0 + 8'(i));
    pushPop(8'h77);
    idle(1'b1);
    popWord();

    // Flush with a push at level 9 keeps error flags; reset with a push clears everything.
    doReset();
    popWord();
    for (int i = 0; i < 9; i++) pushWord(8'h20 + 8'(i));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    idle(1'b1);
    pushWord(8'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    idle(1'b1);

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
